fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_queue.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-aligned reads, tracks up to two
// in-flight requests, buffers returned words in a 2-entry FIFO for decode,
// and flushes/discards stale responses on redirect.
module fetch_queue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_address_i,
  output logic        fetch_request_o,
  output logic [31:0] fetch_address_o,
  input  logic        fetch_grant_i,
  input  logic        fetch_response_i,
  input  logic [31:0] fetch_data_i,
  output logic        valid_decode_o,
  output logic [31:0] instruction_decode_o,
  output logic [31:0] pc_decode_o
);

  localparam logic [31:0] RESET_PC = RESET_VECTOR & ~32'h3;

  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_pc_d    [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic [31:0] req_pc_q     [2];
  logic [31:0] req_pc_d     [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q, discard_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;

  logic        pop, push, issue;
  logic        wr_ptr, req_wr_idx;
  logic [2:0]  occupancy;

  assign valid_decode_o       = (count_q != 2'd0);
  assign instruction_decode_o = valid_decode_o ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign pc_decode_o          = valid_decode_o ? fifo_pc_q[rd_ptr_q]    : 32'h0;

  assign pop = valid_decode_o && !stall_i && !redirect_i;

  // A slot vacated by this cycle's pop may be refilled by this cycle's issue;
  // without that credit a one-cycle bus could only sustain two words in three.
  assign occupancy       = {1'b0, count_q} + {1'b0, outstanding_q} - {2'b00, pop};
  assign fetch_request_o = !redirect_i && (occupancy < 3'd2);
  assign fetch_address_o = fetch_pc_q;
  assign issue           = fetch_request_o && fetch_grant_i;

  // Responses belonging to a flushed stream (or arriving with a redirect) are dropped.
  assign push = fetch_response_i && (discard_q == 2'd0) && !redirect_i;

  // Push lands after the current entries; a push into a full FIFO cannot occur.
  assign wr_ptr = rd_ptr_q ^ count_q[0];

  // Issue only happens with at most one request in flight, so the new request's
  // PC goes into slot 0 or 1 after any same-cycle retirement shifts the tracker.
  assign req_wr_idx = outstanding_q[0] & ~fetch_response_i;

  // Next-state for the decode FIFO.
  always_comb begin
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (redirect_i) begin
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr]    = req_pc_q[0];
        fifo_instr_d[wr_ptr] = fetch_data_i;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Next-state for the fetch PC, in-flight tracking and stale-response discard.
  always_comb begin
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q + {1'b0, issue} - {1'b0, fetch_response_i};
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    if (fetch_response_i) req_pc_d[0] = req_pc_q[1];
    if (issue) req_pc_d[req_wr_idx] = fetch_pc_q;
    // outstanding_q counts every in-flight request, stale or not, so after a
    // redirect all of them (less one retiring now) become stale.
    if (redirect_i) begin
      discard_d  = outstanding_q - {1'b0, fetch_response_i};
      fetch_pc_d = redirect_address_i & ~32'h3;
    end else begin
      if (fetch_response_i && (discard_q != 2'd0)) discard_d = discard_q - 2'd1;
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fifo_pc_q     <= '{default: 32'h0};
      fifo_instr_q  <= '{default: 32'h0};
      req_pc_q      <= '{default: 32'h0};
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      fetch_pc_q    <= RESET_PC;
    end else begin
      fifo_pc_q     <= fifo_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      req_pc_q      <= req_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  // Buffered plus in-flight words never exceed the two FIFO slots.
  a_occupancy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ({1'b0, count_q} + {1'b0, outstanding_q}) <= 3'd2);

  // Stale responses are always a subset of the in-flight ones.
  a_discard: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    discard_q <= outstanding_q);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: bus model with configurable grant/response odds,
// scoreboard of program-order {pc, instruction} refilled at each redirect.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0, grant = 1'b0, response = 1'b0;
  logic [31:0] redirect_address = 32'h0, fetch_data = 32'h0;
  logic        fetch_request, valid_decode;
  logic [31:0] fetch_address, instruction_decode, pc_decode;

  int checks = 0;
  int failures = 0;

  int grant_pct = 100;
  int resp_pct  = 100;

  logic [31:0] bq_addr[$];
  int          bq_age[$];
  logic [31:0] sb_pc[$];

  logic        obs_req, obs_valid, obs_consume, exp_ok;
  logic [31:0] obs_addr, obs_pc, obs_instr, exp_pc, exp_instr;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .stall_i             (stall),
    .redirect_i          (redirect),
    .redirect_address_i  (redirect_address),
    .fetch_request_o     (fetch_request),
    .fetch_address_o     (fetch_address),
    .fetch_grant_i       (grant),
    .fetch_response_i    (response),
    .fetch_data_i        (fetch_data),
    .valid_decode_o      (valid_decode),
    .instruction_decode_o(instruction_decode),
    .pc_decode_o         (pc_decode)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  // Expected program-order stream from a new start address.
  task automatic refill(input logic [31:0] start);
    sb_pc.delete();
    for (int i = 0; i < 512; i++) sb_pc.push_back(start + (32'(i) << 2));
  endtask

  // One bus cycle: drive at negedge, sample before the next posedge.
  task automatic tick(input logic rd, input logic [31:0] rd_addr, input logic stall_v);
    @(negedge clk);
    redirect = rd;
    redirect_address = rd_addr;
    stall = stall_v;
    grant = ($urandom_range(99) < grant_pct);
    response = 1'b0;
    fetch_data = 32'h0;
    if (bq_addr.size() > 0 && bq_age[0] >= 1 && $urandom_range(99) < resp_pct) begin
      response = 1'b1;
      fetch_data = mem_word(bq_addr[0]);
      void'(bq_addr.pop_front());
      void'(bq_age.pop_front());
    end
    if (rd) refill(rd_addr & ~32'h3);
    #3;
    obs_req = fetch_request;
    obs_addr = fetch_address;
    obs_valid = valid_decode;
    obs_pc = pc_decode;
    obs_instr = instruction_decode;
    obs_consume = valid_decode && !stall && !redirect;
    exp_ok = 1'b0;
    if (obs_consume && sb_pc.size() > 0) begin
      exp_ok = 1'b1;
      exp_pc = sb_pc.pop_front();
      exp_instr = mem_word(exp_pc);
    end
    if (fetch_request && grant) begin
      bq_addr.push_back(fetch_address);
      bq_age.push_back(0);
    end
    foreach (bq_age[i]) bq_age[i]++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bq_addr.delete();
    bq_age.delete();
    refill(32'h100);
    @(negedge clk);
    #3;
    checks++;
    if (valid_decode !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_decode); end
    checks++;
    if (instruction_decode !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instruction_decode); end
    checks++;
    if (pc_decode !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_decode); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    int n = 0;
    int first = 0;
    logic seen = 1'b0;
    grant_pct = 100;
    resp_pct = 100;
    for (int t = 1; t <= 12; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (t == 1) begin
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
          failures++; $display("FAIL first_request req=%b addr=%h exp req=1 addr=00000100", obs_req, obs_addr);
        end
      end
      if (seen) begin
        checks++;
        if (obs_valid !== 1'b1) begin failures++; $display("FAIL stream_gap cycle=%0d valid=%b exp=1", t, obs_valid); end
      end
      if (obs_valid && !seen) begin seen = 1'b1; first = t; end
      if (obs_consume) begin
        n++;
        checks++;
        if (!exp_ok || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          failures++; $display("FAIL stream_entry pc=%h instr=%h exp pc=%h instr=%h", obs_pc, obs_instr, exp_pc, exp_instr);
        end
      end
    end
    checks++;
    if (first != 3) begin failures++; $display("FAIL stream_first_valid cycle=%0d exp=3", first); end
    checks++;
    if (n != 10) begin failures++; $display("FAIL stream_count got=%0d exp=10", n); end
  endtask

  task automatic test_stall();
    int n = 0;
    logic [31:0] head;
    head = sb_pc[0];
    for (int t = 0; t < 5; t++) begin
      tick(1'b0, 32'h0, 1'b1);
      checks++;
      if (obs_req !== 1'b0) begin failures++; $display("FAIL stall_request cycle=%0d got=%b exp=0", t, obs_req); end
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== head) begin
        failures++; $display("FAIL stall_hold valid=%b pc=%h exp valid=1 pc=%h", obs_valid, obs_pc, head);
      end
    end
    for (int t = 0; t < 8; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_consume) begin
        n++;
        checks++;
        if (!exp_ok || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          failures++; $display("FAIL stall_resume pc=%h instr=%h exp pc=%h instr=%h", obs_pc, obs_instr, exp_pc, exp_instr);
        end
      end
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL stall_resume_count got=%0d exp=8", n); end
  endtask

  task automatic test_redirect_outstanding();
    logic seen = 1'b0;
    resp_pct = 0;
    for (int t = 0; t < 3; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_consume) begin
        checks++;
        if (!exp_ok || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          failures++; $display("FAIL drain_entry pc=%h exp=%h", obs_pc, exp_pc);
        end
      end
    end
    checks++;
    if (bq_addr.size() != 2) begin failures++; $display("FAIL inflight_count got=%0d exp=2", bq_addr.size()); end
    tick(1'b1, 32'h2000, 1'b0);
    checks++;
    if (obs_req !== 1'b0) begin failures++; $display("FAIL redirect_request got=%b exp=0", obs_req); end
    resp_pct = 100;
    for (int t = 0; t < 12; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_consume) begin
        checks++;
        if (!exp_ok || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          failures++; $display("FAIL redirect2_entry pc=%h instr=%h exp pc=%h instr=%h", obs_pc, obs_instr, exp_pc, exp_instr);
        end
        if (!seen) begin
          seen = 1'b1;
          checks++;
          if (obs_pc !== 32'h2000) begin failures++; $display("FAIL redirect2_first pc=%h exp=00002000", obs_pc); end
        end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL redirect2_timeout valid=0 exp=1"); end
  endtask

  task automatic test_redirect_response();
    logic seen = 1'b0;
    resp_pct = 0;
    for (int t = 0; t < 2; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_consume) begin
        checks++;
        if (!exp_ok || obs_pc !== exp_pc) begin failures++; $display("FAIL pre_redirect_entry pc=%h exp=%h", obs_pc, exp_pc); end
      end
    end
    resp_pct = 100;
    tick(1'b1, 32'h5000, 1'b0);
    checks++;
    if (response !== 1'b1 || obs_req !== 1'b0) begin
      failures++; $display("FAIL redirect_resp_cycle resp=%b req=%b exp resp=1 req=0", response, obs_req);
    end
    tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h5000) begin
      failures++; $display("FAIL redirect_resp_after valid=%b req=%b addr=%h exp valid=0 req=1 addr=00005000", obs_valid, obs_req, obs_addr);
    end
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_consume) begin
        checks++;
        if (!exp_ok || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          failures++; $display("FAIL redirect_resp_entry pc=%h exp=%h", obs_pc, exp_pc);
        end
        if (!seen) begin
          seen = 1'b1;
          checks++;
          if (obs_pc !== 32'h5000) begin failures++; $display("FAIL redirect_resp_first pc=%h exp=00005000", obs_pc); end
        end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL redirect_resp_timeout valid=0 exp=1"); end
  endtask

  task automatic test_latency_align();
    grant_pct = 0;
    for (int t = 0; t < 4; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_consume) begin
        checks++;
        if (!exp_ok || obs_pc !== exp_pc) begin failures++; $display("FAIL idle_drain_entry pc=%h exp=%h", obs_pc, exp_pc); end
      end
    end
    checks++;
    if (obs_valid !== 1'b0 || bq_addr.size() != 0) begin
      failures++; $display("FAIL idle_state valid=%b inflight=%0d exp valid=0 inflight=0", obs_valid, bq_addr.size());
    end
    grant_pct = 100;
    tick(1'b1, 32'h3003, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h3000) begin
      failures++; $display("FAIL latency_issue req=%b addr=%h exp req=1 addr=00003000", obs_req, obs_addr);
    end
    tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (obs_valid !== 1'b0) begin failures++; $display("FAIL latency_early_valid got=%b exp=0", obs_valid); end
    tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (obs_valid !== 1'b1 || !exp_ok || obs_pc !== 32'h3000 || obs_instr !== mem_word(32'h3000)) begin
      failures++; $display("FAIL latency_valid valid=%b pc=%h instr=%h exp valid=1 pc=00003000 instr=%h", obs_valid, obs_pc, obs_instr, mem_word(32'h3000));
    end
  endtask

  task automatic test_wrap();
    logic seen_zero = 1'b0;
    tick(1'b1, 32'hFFFF_FFF8, 1'b0);
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_consume) begin
        checks++;
        if (!exp_ok || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          failures++; $display("FAIL wrap_entry pc=%h instr=%h exp pc=%h instr=%h", obs_pc, obs_instr, exp_pc, exp_instr);
        end
        if (obs_pc === 32'h0) seen_zero = 1'b1;
      end
    end
    checks++;
    if (!seen_zero) begin failures++; $display("FAIL wrap_zero seen=0 exp=1"); end
  endtask

  task automatic test_mid_reset();
    logic seen = 1'b0;
    grant_pct = 100;
    resp_pct = 0;
    tick(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    grant = 1'b0; response = 1'b0; redirect = 1'b0; stall = 1'b0;
    bq_addr.delete();
    bq_age.delete();
    refill(32'h100);
    #3;
    checks++;
    if (valid_decode !== 1'b0 || pc_decode !== 32'h0) begin
      failures++; $display("FAIL midreset_outputs valid=%b pc=%h exp valid=0 pc=0", valid_decode, pc_decode);
    end
    @(negedge clk);
    reset_n = 1'b1;
    resp_pct = 100;
    for (int t = 0; t < 8; t++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_consume) begin
        checks++;
        if (!exp_ok || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          failures++; $display("FAIL midreset_entry pc=%h exp=%h", obs_pc, exp_pc);
        end
        if (!seen) begin
          seen = 1'b1;
          checks++;
          if (obs_pc !== 32'h100) begin failures++; $display("FAIL midreset_first pc=%h exp=00000100", obs_pc); end
        end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midreset_timeout valid=0 exp=1"); end
  endtask

  task automatic test_random();
    int n = 0;
    logic rd;
    logic [31:0] tgt;
    grant_pct = 70;
    resp_pct = 60;
    for (int t = 0; t < 3000; t++) begin
      rd = ($urandom_range(99) < 4);
      tgt = $urandom();
      tick(rd, tgt, ($urandom_range(99) < 30));
      if (obs_consume) begin
        n++;
        checks++;
        if (!exp_ok || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          failures++; $display("FAIL random_entry t=%0d pc=%h instr=%h exp pc=%h instr=%h", t, obs_pc, obs_instr, exp_pc, exp_instr);
        end
      end
    end
    checks++;
    if (n < 200) begin failures++; $display("FAIL random_throughput consumed=%0d exp>=200", n); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_response();
    test_latency_align();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
